// File: rtl/avalon_ram_agent_if.sv
// Avalon-MM read/write port between the core's memory unit (host) and
// the RAM agent.
//
// Handshake: the host raises read or write with address, byteenable and
// host_to_agent, and holds all of them stable while waitrequest is 1.
// A transfer completes in the cycle where waitrequest is 0. For reads,
// that cycle also has readdatavalid=1 and agent_to_host carries the data.
interface avalon_ram_agent_if;
  logic        read;
  logic        write;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic [31:0] host_to_agent;
  logic [31:0] agent_to_host;
  logic        waitrequest;
  logic        readdatavalid;

  modport agent (
    input  read, write, address, byteenable, host_to_agent,
    output agent_to_host, waitrequest, readdatavalid
  );

  modport host (
    output read, write, address, byteenable, host_to_agent,
    input  agent_to_host, waitrequest, readdatavalid
  );
endinterface

// File: rtl/avalon_ram_agent.sv
// Avalon-MM agent serving load/store requests from a word-organised RAM.
// It adds programmable read and write wait states, applies byte-lane
// writes, and flags accesses outside its address window on err.
// dbg_state exposes the FSM state (IDLE reads as 0).
module avalon_ram_agent #(
  parameter int          DEPTH         = 1024,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int          READ_LATENCY  = 2,
  parameter int          WRITE_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  avalon_ram_agent_if.agent   port,
  output logic                err,
  output logic [2:0]          dbg_state
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RWAIT = 3'd1,
    RRESP = 3'd2,
    WWAIT = 3'd3,
    WACK  = 3'd4
  } state_t;

  state_t         state;
  logic [3:0]     cnt;
  logic           wait_q;
  logic           rdv_q;
  logic [31:0]    rdata_q;
  logic [31:0]    mem [DEPTH];

  logic [31:0]    offset;
  logic           in_win;
  logic [AW-1:0]  idx;

  // Window decode. The offset is compared as a whole, so bits above the
  // index also take part in the range check.
  assign offset = port.address - BASE_ADDR;
  assign in_win = (port.address >= BASE_ADDR) && (offset < WIN_BYTES);
  assign idx    = offset[AW+1:2];

  assign port.waitrequest   = wait_q;
  assign port.readdatavalid = rdv_q;
  assign port.agent_to_host = rdata_q;
  assign dbg_state          = state;

  // Transaction FSM. All bus outputs and err are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      wait_q  <= 1'b1;
      rdv_q   <= 1'b0;
      rdata_q <= 32'h0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (port.write) begin
            // A simultaneous read is ignored: the write wins and err
            // reports the conflict.
            if (WRITE_LATENCY == 1) begin
              state  <= WACK;
              wait_q <= 1'b0;
              err    <= port.read | ~in_win;
            end else begin
              state <= WWAIT;
              cnt   <= 4'(WRITE_LATENCY - 1);
              err   <= port.read;
            end
          end else if (port.read) begin
            if (READ_LATENCY == 1) begin
              state   <= RRESP;
              wait_q  <= 1'b0;
              rdv_q   <= 1'b1;
              rdata_q <= in_win ? mem[idx] : 32'h0;
              err     <= ~in_win;
            end else begin
              state <= RWAIT;
              cnt   <= 4'(READ_LATENCY - 1);
            end
          end
        end
        RWAIT: begin
          if (!port.read) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (cnt == 4'd1) begin
            state   <= RRESP;
            cnt     <= 4'd0;
            wait_q  <= 1'b0;
            rdv_q   <= 1'b1;
            rdata_q <= in_win ? mem[idx] : 32'h0;
            err     <= ~in_win;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RRESP: begin
          state  <= IDLE;
          wait_q <= 1'b1;
          rdv_q  <= 1'b0;
        end
        WWAIT: begin
          if (!port.write) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (cnt == 4'd1) begin
            state  <= WACK;
            cnt    <= 4'd0;
            wait_q <= 1'b0;
            err    <= ~in_win;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WACK: begin
          state  <= IDLE;
          wait_q <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          wait_q <= 1'b1;
          rdv_q  <= 1'b0;
        end
      endcase
    end
  end

  // Write commit on the closing edge of the acknowledge cycle. Reset
  // suppresses it, so an aborted write never lands in the RAM.
  always_ff @(posedge clk) begin
    if (!rst && state == WACK && in_win) begin
      for (int b = 0; b < 4; b++) begin
        if (port.byteenable[b]) begin
          mem[idx][8*b +: 8] <= port.host_to_agent[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_avalon_ram_agent.sv
// Bench for avalon_ram_agent. Two instances with different latencies and
// windows share one set of host drive signals, and sel picks the active
// instance. The reference RAM is an associative array of words per instance.
module tb_avalon_ram_agent;

  localparam int          DA = 1024;
  localparam logic [31:0] BA = 32'h0001_0000;
  localparam int          DB = 16;
  localparam logic [31:0] BB = 32'h2000_0000;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        h_read = 1'b0;
  logic        h_write = 1'b0;
  logic [31:0] h_addr = 32'h0;
  logic [31:0] h_wdata = 32'h0;
  logic [3:0]  h_be = 4'h0;

  avalon_ram_agent_if if_a ();
  avalon_ram_agent_if if_b ();

  assign if_a.read          = h_read & ~sel;
  assign if_a.write         = h_write & ~sel;
  assign if_a.address       = h_addr;
  assign if_a.byteenable    = h_be;
  assign if_a.host_to_agent = h_wdata;
  assign if_b.read          = h_read & sel;
  assign if_b.write         = h_write & sel;
  assign if_b.address       = h_addr;
  assign if_b.byteenable    = h_be;
  assign if_b.host_to_agent = h_wdata;

  logic       err_a, err_b;
  logic [2:0] dbg_a, dbg_b;

  avalon_ram_agent #(.DEPTH(DA), .BASE_ADDR(BA), .READ_LATENCY(2), .WRITE_LATENCY(1))
    dut_a (.clk(clk), .rst(rst), .port(if_a), .err(err_a), .dbg_state(dbg_a));
  avalon_ram_agent #(.DEPTH(DB), .BASE_ADDR(BB), .READ_LATENCY(4), .WRITE_LATENCY(3))
    dut_b (.clk(clk), .rst(rst), .port(if_b), .err(err_b), .dbg_state(dbg_b));

  logic        o_wait, o_rdv, o_err;
  logic [31:0] o_data;
  logic [2:0]  o_dbg;
  assign o_wait = sel ? if_b.waitrequest   : if_a.waitrequest;
  assign o_rdv  = sel ? if_b.readdatavalid : if_a.readdatavalid;
  assign o_data = sel ? if_b.agent_to_host : if_a.agent_to_host;
  assign o_err  = sel ? err_b : err_a;
  assign o_dbg  = sel ? dbg_b : dbg_a;

  // Reference RAM contents, keyed by word index.
  logic [31:0] ref_a [int];
  logic [31:0] ref_b [int];

  function automatic bit ref_in_win(input bit s, input logic [31:0] a);
    longint base = s ? longint'({32'h0, BB}) : longint'({32'h0, BA});
    longint size = 4 * (s ? DB : DA);
    longint aa   = longint'({32'h0, a});
    return (aa >= base) && (aa < base + size);
  endfunction

  function automatic int ref_idx(input bit s, input logic [31:0] a);
    longint base = s ? longint'({32'h0, BB}) : longint'({32'h0, BA});
    return int'((longint'({32'h0, a}) - base) / 4);
  endfunction

  function automatic logic [31:0] ref_read(input bit s, input logic [31:0] a);
    int i;
    if (!ref_in_win(s, a)) return 32'h0;
    i = ref_idx(s, a);
    if (s) return ref_b.exists(i) ? ref_b[i] : 32'hx;
    return ref_a.exists(i) ? ref_a[i] : 32'hx;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w;
    int i;
    if (!ref_in_win(sel, a)) return;
    i = ref_idx(sel, a);
    w = ref_read(sel, a);
    for (int b = 0; b < 4; b++)
      if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    if (sel) ref_b[i] = w; else ref_a[i] = w;
  endtask

  // Driver: one write; checks the ack position, the err pulses and that
  // readdatavalid stays low.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          input bit also_read, input bit chain);
    int wl = sel ? 3 : 1;
    bit win = ref_in_win(sel, a);
    bit ew;
    h_write = 1'b1; h_read = also_read; h_addr = a; h_wdata = d; h_be = be;
    for (int k = 0; k <= wl; k++) begin
      @(negedge clk);
      ew = (also_read && k == 1) || (!win && k == wl);
      checks++;
      if (o_wait !== (k != wl)) begin
        failures++; $display("FAIL wr_wait a=%h k=%0d got=%b exp=%b", a, k, o_wait, k != wl);
      end
      checks++;
      if (o_rdv !== 1'b0) begin
        failures++; $display("FAIL wr_rdv a=%h k=%0d got=%b exp=0", a, k, o_rdv);
      end
      checks++;
      if (o_err !== ew) begin
        failures++; $display("FAIL wr_err a=%h k=%0d got=%b exp=%b", a, k, o_err, ew);
      end
      @(posedge clk); #1;
    end
    ref_write(a, d, be);
    h_write = 1'b0; h_read = 1'b0;
    if (!chain) begin
      @(negedge clk);
      checks++;
      if (o_wait !== 1'b1 || o_err !== 1'b0) begin
        failures++; $display("FAIL wr_idle a=%h got wait=%b err=%b exp wait=1 err=0", a, o_wait, o_err);
      end
      @(posedge clk); #1;
    end
  endtask

  // Driver: one read; checks that the response arrives exactly READ_LATENCY
  // cycles after acceptance, and checks the data, err and data hold.
  task automatic do_read(input logic [31:0] a, input bit chain);
    int rl = sel ? 4 : 2;
    bit win = ref_in_win(sel, a);
    logic [31:0] exp = ref_read(sel, a);
    h_read = 1'b1; h_write = 1'b0; h_addr = a;
    for (int k = 0; k <= rl; k++) begin
      @(negedge clk);
      checks++;
      if (o_wait !== (k != rl) || o_rdv !== (k == rl)) begin
        failures++;
        $display("FAIL rd_hs a=%h k=%0d got wait=%b rdv=%b exp wait=%b rdv=%b",
                 a, k, o_wait, o_rdv, k != rl, k == rl);
      end
      checks++;
      if (o_err !== (!win && k == rl)) begin
        failures++; $display("FAIL rd_err a=%h k=%0d got=%b exp=%b", a, k, o_err, !win && k == rl);
      end
      if (k == rl) begin
        checks++;
        if (o_data !== exp) begin
          failures++; $display("FAIL rd_data a=%h got=%h exp=%h", a, o_data, exp);
        end
      end
      @(posedge clk); #1;
    end
    h_read = 1'b0;
    if (!chain) begin
      @(negedge clk);
      checks++;
      if (o_wait !== 1'b1 || o_rdv !== 1'b0 || o_data !== exp) begin
        failures++;
        $display("FAIL rd_hold a=%h got wait=%b rdv=%b data=%h exp wait=1 rdv=0 data=%h",
                 a, o_wait, o_rdv, o_data, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (if_a.waitrequest !== 1'b1 || if_a.readdatavalid !== 1'b0 || if_a.agent_to_host !== 32'h0 ||
        err_a !== 1'b0 || dbg_a !== 3'd0) begin
      failures++;
      $display("FAIL reset_a got wait=%b rdv=%b data=%h err=%b st=%0d exp 1 0 0 0 0",
               if_a.waitrequest, if_a.readdatavalid, if_a.agent_to_host, err_a, dbg_a);
    end
    checks++;
    if (if_b.waitrequest !== 1'b1 || if_b.readdatavalid !== 1'b0 || if_b.agent_to_host !== 32'h0 ||
        err_b !== 1'b0 || dbg_b !== 3'd0) begin
      failures++;
      $display("FAIL reset_b got wait=%b rdv=%b data=%h err=%b st=%0d exp 1 0 0 0 0",
               if_b.waitrequest, if_b.readdatavalid, if_b.agent_to_host, err_b, dbg_b);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    sel = 1'b0;
    do_write(BA + 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
    do_read(BA + 32'h10, 1'b0);
  endtask

  task automatic test_byte_lanes();
    sel = 1'b0;
    do_write(BA + 32'h20, 32'h1122_3344, 4'hF, 1'b0, 1'b0);
    do_write(BA + 32'h22, 32'hAABB_CCDD, 4'b0001, 1'b0, 1'b0);
    do_read(BA + 32'h20, 1'b0);
    do_write(BA + 32'h22, 32'hAABB_CCDD, 4'b0011, 1'b0, 1'b0);
    do_read(BA + 32'h23, 1'b0);
    do_write(BA + 32'h20, 32'h0BAD_F00D, 4'b0000, 1'b0, 1'b0);
    do_read(BA + 32'h20, 1'b0);
  endtask

  task automatic test_out_of_window();
    sel = 1'b0;
    do_write(BA, 32'h0102_0304, 4'hF, 1'b0, 1'b0);
    do_read(BA + 32'(4 * DA), 1'b0);
    do_write(BA + 32'(4 * DA), 32'h5555_5555, 4'hF, 1'b0, 1'b0);
    do_write(BA - 32'd4, 32'h6666_6666, 4'hF, 1'b0, 1'b0);
    do_read(BA - 32'd4, 1'b0);
    do_read(BA, 1'b0);
    sel = 1'b1;
    do_write(BB, 32'h0A0B_0C0D, 4'hF, 1'b0, 1'b0);
    do_write(BB + 32'(4 * DB), 32'h7777_7777, 4'hF, 1'b0, 1'b0);
    do_read(BB + 32'(4 * DB), 1'b0);
    do_read(BB, 1'b0);
  endtask

  task automatic test_conflict();
    sel = 1'b0;
    do_write(BA + 32'h30, 32'h1234_5678, 4'hF, 1'b0, 1'b0);
    do_write(BA + 32'h30, 32'hCAFE_F00D, 4'b0110, 1'b1, 1'b0);
    do_read(BA + 32'h30, 1'b0);
    sel = 1'b1;
    do_write(BB + 32'h8, 32'h1357_9BDF, 4'hF, 1'b0, 1'b0);
    do_write(BB + 32'h8, 32'hFEED_FACE, 4'b1001, 1'b1, 1'b0);
    do_read(BB + 32'h8, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      do_write((sel ? BB : BA) + 32'h14, $urandom, 4'hF, 1'b0, 1'b1);
      do_read((sel ? BB : BA) + 32'h14, 1'b1);
      do_write((sel ? BB : BA) + 32'h14, $urandom, 4'($urandom_range(0, 15)), 1'b0, 1'b1);
      do_read((sel ? BB : BA) + 32'h14, 1'b1);
      do_read((sel ? BB : BA) + 32'h14, 1'b0);
    end
  endtask

  task automatic test_drop();
    sel = 1'b1;
    do_write(BB + 32'h4, 32'h4444_4441, 4'hF, 1'b0, 1'b0);
    do_write(BB + 32'h8, 32'h8888_8881, 4'hF, 1'b0, 1'b0);
    do_read(BB + 32'h8, 1'b0);
    // Read dropped in cycle n+2: no response, IDLE from n+3.
    h_read = 1'b1; h_addr = BB + 32'h4;
    for (int k = 0; k <= 6; k++) begin
      if (k == 2) h_read = 1'b0;
      @(negedge clk);
      checks++;
      if (o_wait !== 1'b1 || o_rdv !== 1'b0) begin
        failures++; $display("FAIL rd_drop k=%0d got wait=%b rdv=%b exp wait=1 rdv=0", k, o_wait, o_rdv);
      end
      if (k == 3) begin
        checks++;
        if (o_dbg !== 3'd0) begin
          failures++; $display("FAIL rd_drop_idle got st=%0d exp=0", o_dbg);
        end
      end
      @(posedge clk); #1;
    end
    // Write dropped in cycle n+1: no ack and no commit.
    h_write = 1'b1; h_addr = BB + 32'h8; h_wdata = 32'hBADB_AD00; h_be = 4'hF;
    for (int k = 0; k <= 5; k++) begin
      if (k == 1) h_write = 1'b0;
      @(negedge clk);
      checks++;
      if (o_wait !== 1'b1 || o_err !== 1'b0) begin
        failures++; $display("FAIL wr_drop k=%0d got wait=%b err=%b exp wait=1 err=0", k, o_wait, o_err);
      end
      @(posedge clk); #1;
    end
    do_read(BB + 32'h8, 1'b0);
  endtask

  task automatic test_reset_mid();
    sel = 1'b1;
    do_write(BB + 32'hC, 32'hC0C0_C0C1, 4'hF, 1'b0, 1'b0);
    do_write(BB + 32'h10, 32'h1010_1011, 4'hF, 1'b0, 1'b0);
    do_read(BB + 32'h8, 1'b0);
    h_write = 1'b1; h_addr = BB + 32'h10; h_wdata = 32'hFFFF_FFFF; h_be = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; h_write = 1'b0;
    @(negedge clk);
    checks++;
    if (o_wait !== 1'b1 || o_rdv !== 1'b0 || o_data !== 32'h0 || o_err !== 1'b0 || o_dbg !== 3'd0) begin
      failures++;
      $display("FAIL mid_reset got wait=%b rdv=%b data=%h err=%b st=%0d exp 1 0 0 0 0",
               o_wait, o_rdv, o_data, o_err, o_dbg);
    end
    @(posedge clk); #1;
    do_read(BB + 32'h10, 1'b0);
    do_read(BB + 32'hC, 1'b0);
    sel = 1'b0;
    do_read(BA + 32'h10, 1'b0);
    do_read(BA + 32'h20, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] base, a;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      base = sel ? BB : BA;
      for (int i = 0; i < 8; i++) do_write(base + 32'(4 * i), $urandom, 4'hF, 1'b0, 1'b0);
    end
    for (int i = 0; i < 60; i++) begin
      sel = 1'($urandom_range(0, 1));
      base = sel ? BB : BA;
      a = base + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0)
        a = base + 32'(4 * (sel ? DB : DA)) + 32'(4 * $urandom_range(0, 63));
      case ($urandom_range(0, 2))
        0: do_write(a, $urandom, 4'($urandom_range(0, 15)), 1'b0, 1'($urandom_range(0, 1)));
        1: do_write(a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
        default: do_read(a, 1'($urandom_range(0, 1)));
      endcase
    end
    h_read = 1'b0; h_write = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_lanes();
    test_out_of_window();
    test_conflict();
    test_back_to_back();
    test_drop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
